// File: rtl/toggle_pkg.sv
// toggle_pkg
//   Shared constants for the pushbutton toggle-pulse generator and the
//   four-bit T flip-flop counter that consumes its pulses.
//   - ST_* : 3-bit FSM state encodings
//   - DEF_*: default parameter values
//   - state_t: enum built on the ST_* encodings
package toggle_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARM    = 3'd1;
   localparam logic [2:0] ST_HELD   = 3'd2;
   localparam logic [2:0] ST_REPEAT = 3'd3;
   localparam logic [2:0] ST_DISARM = 3'd4;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_REPEAT_DELAY    = 16;
   localparam int DEF_REPEAT_PERIOD   = 8;
   localparam int DEF_CNT_W           = 16;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_ARM    = ST_ARM,
      S_HELD   = ST_HELD,
      S_REPEAT = ST_REPEAT,
      S_DISARM = ST_DISARM
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   1-bit two-flop synchroniser for asynchronous inputs.
//   Ports:
//     i_clk   - destination clock (posedge)
//     i_reset - synchronous reset, active-low; clears both flops
//     i_d     - asynchronous input
//     o_q     - synchronised output, two cycles of latency
module sync_2ff (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen
//   Turns a raw pushbutton into single-cycle toggle pulses for the counter's
//   T flip-flop chain: synchronise, debounce press/release, optional
//   auto-repeat while held. All outputs are registered on posedge clk so
//   t_out is stable at the counter's negedge sample point.
//   Ports:
//     clk           - system clock
//     reset         - synchronous reset, active-low
//     btn_in        - raw asynchronous button, active-high
//     en            - pulse enable; gates t_out only, FSM keeps running
//     t_out         - one-cycle toggle pulse
//     btn_db        - debounced button level
//     repeat_active - high while in auto-repeat
module toggle_pulse_gen
   import toggle_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   input  logic en,
   output logic t_out,
   output logic btn_db,
   output logic repeat_active
);

   localparam logic             REPEAT_EN = (REPEAT_DELAY != 0);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Only meaningful when REPEAT_EN; guarded at the point of use.
   localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(REPEAT_PERIOD - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_btn_s;

   sync_2ff u_sync (
      .i_clk   (clk),
      .i_reset (reset),
      .i_d     (btn_in),
      .o_q     (w_btn_s)
   );

   // IDLE and HELD (with repeat disabled) can sit forever, so the counter
   // saturates rather than wrapping; compare points are all far below max.
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         t_out         <= 1'b0;
         btn_db        <= 1'b0;
         repeat_active <= 1'b0;
      end else begin
         t_out <= 1'b0;
         r_cnt <= w_cnt_inc;
         case (r_state)
            S_IDLE: begin
               if (w_btn_s) begin
                  r_state <= S_ARM;
                  r_cnt   <= '0;
               end
            end
            S_ARM: begin
               if (!w_btn_s) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == DB_LAST) begin
                  r_state <= S_HELD;
                  r_cnt   <= '0;
                  btn_db  <= 1'b1;
                  t_out   <= en;
               end
            end
            S_HELD: begin
               if (!w_btn_s) begin
                  r_state <= S_DISARM;
                  r_cnt   <= '0;
               end else if (REPEAT_EN && (r_cnt == RD_LAST)) begin
                  r_state       <= S_REPEAT;
                  r_cnt         <= '0;
                  t_out         <= en;
                  repeat_active <= 1'b1;
               end
            end
            S_REPEAT: begin
               if (!w_btn_s) begin
                  r_state       <= S_DISARM;
                  r_cnt         <= '0;
                  repeat_active <= 1'b0;
               end else if (r_cnt == RP_LAST) begin
                  r_cnt <= '0;
                  t_out <= en;
               end
            end
            S_DISARM: begin
               // Re-press during release debounce: back to HELD silently,
               // repeat delay starts over from the cleared counter.
               if (w_btn_s) begin
                  r_state <= S_HELD;
                  r_cnt   <= '0;
               end else if (r_cnt == DB_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  btn_db  <= 1'b0;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_cnt         <= '0;
               btn_db        <= 1'b0;
               repeat_active <= 1'b0;
            end
         endcase
      end
   end

endmodule
